// File: rtl/ntru_pkg.sv
// Shared constants and types for the NTRU polynomial packers.
package ntru_pkg;

    localparam int N          = 701;
    localparam int LOGQ       = 13;
    localparam int COEF_W     = 16;
    localparam int ACC_W      = 24;
    localparam int CNT_W      = 5;
    localparam int IDX_W      = 10;
    localparam int BCNT_W     = 11;
    localparam int LOAD_MAX   = ACC_W - LOGQ;
    localparam int PACK_RQ0_BYTES = ((N - 1) * LOGQ + 7) / 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } pack_state_e;

endpackage

// File: rtl/gearbox_13to8.sv
// 13-bit in, 8-bit out LSB-first bit accumulator with ready/valid rules.
module gearbox_13to8
    import ntru_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              flush,
    input  logic              insert,
    input  logic [COEF_W-1:0] coef,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_fire,
    output logic [7:0]        out_byte,
    output logic [CNT_W-1:0]  bit_cnt
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sh;
    logic [ACC_W-1:0]  acc_nx;
    logic [CNT_W-1:0]  cnt_sh;
    logic [CNT_W-1:0]  cnt_nx;
    logic [COEF_W-1:0] coef_m;
    logic              has_byte;

    // Bits above bit_cnt are always zero, so a residual byte is padded for free.
    always_comb begin
        coef_m    = coef & COEF_W'((1 << LOGQ) - 1);
        has_byte  = (bit_cnt >= CNT_W'(8));
        in_ready  = load && (bit_cnt <= CNT_W'(LOAD_MAX));
        out_valid = (load && has_byte) || (flush && (bit_cnt != '0));
        out_byte  = acc[7:0];
        out_fire  = out_valid && out_ready;

        acc_sh = acc;
        cnt_sh = bit_cnt;
        if (out_fire) begin
            acc_sh = acc >> 8;
            cnt_sh = has_byte ? (bit_cnt - CNT_W'(8)) : '0;
        end

        acc_nx = acc_sh;
        cnt_nx = cnt_sh;
        if (insert) begin
            acc_nx = acc_sh | (ACC_W'(coef_m) << cnt_sh);
            cnt_nx = cnt_sh + CNT_W'(LOGQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            acc     <= acc_nx;
            bit_cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/pack_rq0.sv
// Streaming Rq packer: N coefficients in, LSB-first 13-bit packed bytes out.
module pack_rq0
    import ntru_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COEF_W-1:0] in_coef,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [BCNT_W-1:0] byte_cnt
);

    pack_state_e      state;
    pack_state_e      state_nx;
    logic [IDX_W-1:0] coef_idx;
    logic [CNT_W-1:0] bit_cnt;
    logic             load;
    logic             flush;
    logic             clear;
    logic             accept;
    logic             last;
    logic             insert;
    logic             out_fire;

    gearbox_13to8 u_gearbox (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .flush     (flush),
        .insert    (insert),
        .coef      (in_coef),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_fire  (out_fire),
        .out_byte  (out_byte),
        .bit_cnt   (bit_cnt)
    );

    // The final coefficient is accepted but never inserted.
    always_comb begin
        load     = (state == LOAD);
        flush    = (state == FLUSH);
        clear    = (state == IDLE) && start;
        accept   = in_valid && in_ready;
        last     = (coef_idx == IDX_W'(N - 1));
        insert   = accept && !last;
        busy     = load || flush;
        done     = (state == DONE);
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  if (accept && last) state_nx = FLUSH;
            FLUSH: if (bit_cnt == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            coef_idx <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                coef_idx <= '0;
                byte_cnt <= '0;
            end else begin
                if (insert)
                    coef_idx <= coef_idx + IDX_W'(1);
                if (out_fire)
                    byte_cnt <= byte_cnt + BCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pack_rq0.sv
// Directed bench for pack_rq0 with a bit-position reference model.
module tb_pack_rq0;
    import ntru_pkg::*;

    localparam int NB = PACK_RQ0_BYTES;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_coef;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [10:0] byte_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] coef [N];
    logic [7:0]  expb [NB];
    logic [7:0]  got  [NB];

    always #5 clk = ~clk;

    pack_rq0 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_coef   (in_coef),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .byte_cnt  (byte_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream bit 13*i+j carries bit j of coefficient i; c[N-1] never appears.
    task automatic build_model();
        for (int b = 0; b < NB; b++) begin
            expb[b] = 8'h00;
            got[b]  = 8'hxx;
        end
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < LOGQ; j++) begin
                int p;
                p = 13 * i + j;
                if (coef[i][j]) expb[p / 8][p % 8] = 1'b1;
            end
    endtask

    task automatic run(input int pv, input int pr,
                       input int start_at, input int abort_at);
        int   idx;
        int   nb;
        int   cyc;
        bit   stall;
        bit   extra;
        bit   fin;
        logic [7:0] pb;
        idx = 0; nb = 0; cyc = 0;
        stall = 0; extra = 0; fin = 0; pb = 8'h00;
        build_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            if (done) begin
                fin = 1;
            end else begin
                if (nb == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("abort_out_valid", 32'(out_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_in_ready", 32'(in_ready), 32'd0);
                    in_valid  = 1'b0;
                    out_ready = 1'b0;
                    @(posedge clk);
                    #1 rst = 1'b0;
                    @(negedge clk);
                    return;
                end
                in_valid  = (idx < N) && ($urandom_range(99) < pv);
                in_coef   = (idx < N) ? coef[idx] : 16'($urandom);
                out_ready = ($urandom_range(99) < pr);
                start     = (nb == start_at) && !extra;
                if (start) extra = 1;
                #1;
                if (stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_byte", 32'(out_byte), 32'(pb));
                end
                if (out_valid && out_ready) begin
                    if (nb < NB) begin
                        chk($sformatf("byte%0d", nb), 32'(out_byte),
                            32'(expb[nb]));
                        got[nb] = out_byte;
                    end
                    nb++;
                end
                if (in_valid && in_ready) idx++;
                stall = out_valid && !out_ready;
                pb    = out_byte;
                @(negedge clk);
                cyc++;
            end
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("timeout", 32'(fin), 32'd1);
        chk("nbytes", 32'(nb), 32'(NB));
        chk("coefs_taken", 32'(idx), 32'(N));
        chk("byte_cnt", 32'(byte_cnt), 32'(NB));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("byte_cnt_hold", 32'(byte_cnt), 32'(NB));
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_coef   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        #1 chk("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N; i++) coef[i] = 16'h0000;
        coef[0] = 16'h1FFF;
        coef[2] = 16'h0001;
        run(100, 100, -1, -1);
        chk("basic_b0", 32'(got[0]), 32'h00FF);
        chk("basic_b1", 32'(got[1]), 32'h001F);
        chk("basic_b2", 32'(got[2]), 32'h0000);
        chk("basic_b3", 32'(got[3]), 32'h0004);
        chk("basic_b4", 32'(got[4]), 32'h0000);

        for (int i = 0; i < N; i++) coef[i] = 16'hFFFF;
        run(100, 100, -1, -1);
        chk("ones_b0", 32'(got[0]), 32'h00FF);
        chk("ones_b1136", 32'(got[1136]), 32'h00FF);
        chk("ones_last", 32'(got[NB-1]), 32'h000F);

        coef[N-1] = 16'h0000;
        run(100, 100, -1, -1);
        chk("drop_last", 32'(got[NB-1]), 32'h000F);

        for (int i = 0; i < N; i++) coef[i] = 16'($urandom);
        run(70, 30, 100, -1);

        for (int i = 0; i < N; i++) coef[i] = 16'($urandom);
        run(90, 90, -1, 500);
        chk("post_abort_byte_cnt", 32'(byte_cnt), 32'd0);
        run(80, 60, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
